window_gen_3x3: RTL and testbench
=================================

// Module: window_gen_3x3
// PURPOSE
//  Turns the raster RGB444 pixel stream from the camera capture path into 3x3 neighbourhoods.
//  Each output window is nine 12-bit taps (left/mid/right column x up/mid/down row), emitted one per accepted pixel.
//  The taps drive the combinational fuzzy/morphological edge filter.
//  Only interior windows are emitted. Downstream uses out_x/out_y to place the result and blacks out the 1-pixel border.
// PARAMETERS
//  IMG_W  640  active pixels per line (>=3)
//  IMG_H  480  active lines per frame (>=3)
//  PIX_W  12   pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}
// PORTS
//  clk         in   1                 pixel clock domain; all logic on rising edge
//  rst         in   1                 synchronous, active-high reset
//  in_valid    in   1                 in_pixel is valid this cycle; no backpressure, always accepted
//  in_sof      in   1                 qualified by in_valid: this pixel is (0,0) of a new frame
//  in_pixel    in   PIX_W             raster-order pixel
//  out_valid   out  1                 1-cycle pulse: taps and coordinates below are a new window
//  out_lu..out_rd out PIX_W each (x9) taps lu,lm,ld,mu,mm,md,ru,rm,rd; l=x-1, r=x+1, u=y-1, d=y+1
//  out_x       out  $clog2(IMG_W)     window centre column
//  out_y       out  $clog2(IMG_H)     window centre row
//  frame_done  out  1                 1-cycle pulse with the window for the last pixel (IMG_W-1,IMG_H-1)
// BEHAVIOUR
//  Reset
//   - col=0, row=0; all 3x3 tap registers 0.
//   - out_valid=0, frame_done=0, out_x=0, out_y=0.
//   - Line-buffer RAM contents are not reset. Stale data must never reach a valid window.
//  Accepted pixel at (col,row), in_valid=1
//   - Read lb0[col] (row-1) and lb1[col] (row-2).
//   - Write lb1[col]<=lb0[col] and lb0[col]<=in_pixel in the same cycle (read-before-write).
//   - Shift the window left by one column: l<=m, m<=r.
//   - New r column: ru=lb1[col], rm=lb0[col], rd=in_pixel.
//  Output
//   - Window is valid iff col>=2 && row>=2.
//   - When valid: next cycle out_valid=1, out_x=col-1, out_y=row-1, and the taps present the new window.
//   - Latency: exactly 1 cycle after the accepting edge.
//  Idle and frame boundaries
//   - in_valid=0: counters, taps and RAM hold; out_valid=0 the next cycle. Arbitrary gaps are legal.
//   - col wraps IMG_W-1 -> 0 with row+1.
//   - At (IMG_W-1,IMG_H-1): emit the window with frame_done=1, then col=row=0. The next pixel is frame start even without in_sof.
//  in_sof
//   - in_sof with in_valid: that pixel is treated as (0,0) regardless of current counters; the partial frame is abandoned.
//   - No window is emitted for it or for the rest of rows 0-1, so stale RAM and taps are overwritten before use.
//   - in_sof without in_valid is ignored.
//  Per-frame totals
//   - Exactly (IMG_W-2)*(IMG_H-2) windows.
//   - Column-0/1 windows in each row are suppressed, so taps crossing a line boundary are never valid.
//  rst mid-frame
//   - Next cycle: outputs at reset values.
//   - The next accepted pixel is (0,0).
// STRUCTURE
//  Package window_pkg
//   - IMG_W/IMG_H defaults, PIX_W.
//   - COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H).
//   - pixel_t typedef; tap index constants LU..RD (0..8, same order as ports).
//  Sub-module line_buffer #(DEPTH=IMG_W, W=PIX_W)
//   - Async read, sync write, no reset.
//   - Instantiated twice (lb0, lb1); maps to distributed RAM.
//  Top-level contents
//   - Counters, 3x3 shift registers, valid/coordinate registers.
//   - No FSM beyond the col/row counters.
// TESTING (use IMG_W=8, IMG_H=6, pixel=(row<<4)|col unless noted)
//  1 Full frame, in_sof on first pixel, in_valid continuous
//    -> 24 windows, centres (1..6,1..4) in raster order.
//    -> First window one cycle after accepting pixel (2,2): out_x=1, out_y=1, lu=0x000, mm=0x011, rd=0x022, ru=0x002, ld=0x020.
//  2 Same frame with random in_valid gaps (~50%)
//    -> identical window/coordinate sequence; out_valid never asserted in a gap-following cycle without an accept.
//  3 in_sof re-asserted at pixel (4,3), then a fresh full frame
//    -> no window after the restart until the new (2,2) accept; then 24 correct windows, none contain old-frame values.
//  4 rst asserted for 1 cycle at (5,3), then a full frame
//    -> next cycle out_valid=0 and all taps 0; the following frame yields the exact sequence of test 1.
//  5 Two back-to-back frames, second frame pixel=0x800|(row<<4)|col, in_sof only on first frame
//    -> frame_done pulses exactly twice, coincident with windows (6,4).
//    -> All second-frame taps have bit 11 set (no leakage).
//  6 Default 640x480, random pixels vs. reference model
//    -> 638*478=304964 windows; all taps match the model; frame_done once.

Source files
------------

// File: rtl/window_pkg.sv
// Shared sizing constants, pixel type and tap indices for the 3x3 window generator.
package window_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned PIX_W_DEF = 12;

  localparam int unsigned COL_W = $clog2(IMG_W_DEF);
  localparam int unsigned ROW_W = $clog2(IMG_H_DEF);

  // RGB444 pixel: {R[11:8], G[7:4], B[3:0]}
  typedef logic [PIX_W_DEF-1:0] pixel_t;

  // Tap order matches the output port order: column-major, l/m/r by u/m/d.
  localparam int unsigned LU = 0;
  localparam int unsigned LM = 1;
  localparam int unsigned LD = 2;
  localparam int unsigned MU = 3;
  localparam int unsigned MM = 4;
  localparam int unsigned MD = 5;
  localparam int unsigned RU = 6;
  localparam int unsigned RM = 7;
  localparam int unsigned RD = 8;
  localparam int unsigned NUM_TAPS = 9;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One line of pixel storage: asynchronous read, synchronous write, no reset.
module line_buffer
  import window_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_W_DEF,
  parameter int unsigned W     = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Read returns the old contents at addr in the same cycle as the write.
  assign rdata = mem[addr];

  // Write the incoming column value on accept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 interior neighbourhoods, one window per accepted pixel.
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic                     out_valid,
  output logic [PIX_W-1:0]         out_lu,
  output logic [PIX_W-1:0]         out_lm,
  output logic [PIX_W-1:0]         out_ld,
  output logic [PIX_W-1:0]         out_mu,
  output logic [PIX_W-1:0]         out_mm,
  output logic [PIX_W-1:0]         out_md,
  output logic [PIX_W-1:0]         out_ru,
  output logic [PIX_W-1:0]         out_rm,
  output logic [PIX_W-1:0]         out_rd,
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_H)-1:0] out_y,
  output logic                     frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             win_ok;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] tap [NUM_TAPS];

  // Effective position of the pixel being accepted; in_sof forces (0,0).
  always_comb begin
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    win_ok   = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
  end

  // lb0 holds row-1, lb1 holds row-2; lb1 is fed from lb0's pre-write value.
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) lb0 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (cur_col),
    .wdata (in_pixel),
    .rdata (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) lb1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (cur_col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // Raster position counters, wrapping at line and frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // 3x3 shift window: columns move left, new right column from RAM and input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        tap[i] <= '0;
      end
    end else if (in_valid) begin
      tap[LU] <= tap[MU];
      tap[LM] <= tap[MM];
      tap[LD] <= tap[MD];
      tap[MU] <= tap[RU];
      tap[MM] <= tap[RM];
      tap[MD] <= tap[RD];
      tap[RU] <= lb1_q;
      tap[RM] <= lb0_q;
      tap[RD] <= in_pixel;
    end
  end

  // Window valid strobe, centre coordinates and end-of-frame marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid  <= in_valid && win_ok;
      frame_done <= in_valid && win_ok && last_col && last_row;
      if (in_valid && win_ok) begin
        out_x <= cur_col - CW'(1);
        out_y <= cur_row - RW'(1);
      end
    end
  end

  assign out_lu = tap[LU];
  assign out_lm = tap[LM];
  assign out_ld = tap[LD];
  assign out_mu = tap[MU];
  assign out_mm = tap[MM];
  assign out_md = tap[MD];
  assign out_ru = tap[RU];
  assign out_rm = tap[RM];
  assign out_rd = tap[RD];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on an 8x6 image.
module tb_window_gen_3x3;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic [PW-1:0] out_lu, out_lm, out_ld, out_mu, out_mm, out_md, out_ru, out_rm, out_rd;
  logic [2:0]    out_x;
  logic [2:0]    out_y;
  logic          frame_done;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_lu     (out_lu),
    .out_lm     (out_lm),
    .out_ld     (out_ld),
    .out_mu     (out_mu),
    .out_mm     (out_mm),
    .out_md     (out_md),
    .out_ru     (out_ru),
    .out_rm     (out_rm),
    .out_rd     (out_rd),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][PW-1:0] taps;
    int                 x;
    int                 y;
    logic               fd;
  } win_t;

  win_t          exp_q[$];
  logic [PW-1:0] img [H][W];
  int            mc, mr;
  int            checks, fails;
  int            win_seen, fd_seen;
  bit            mon_en;

  // Reference model: track raster position, remember the frame, build windows.
  task automatic model_accept(input logic [PW-1:0] pix, input bit sof);
    win_t e;
    if (sof) begin
      mc = 0;
      mr = 0;
    end
    img[mr][mc] = pix;
    if (mc >= 2 && mr >= 2) begin
      for (int dx = 0; dx < 3; dx++)
        for (int dy = 0; dy < 3; dy++)
          e.taps[dx*3+dy] = img[mr-2+dy][mc-2+dx];
      e.x  = mc - 1;
      e.y  = mr - 1;
      e.fd = (mc == W-1) && (mr == H-1);
      exp_q.push_back(e);
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] pix, input bit sof);
    model_accept(pix, sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Idle cycles; in_sof toggles randomly to show it is ignored without in_valid.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_pixel = PW'($urandom);
      step();
    end
    in_sof = 1'b0;
  endtask

  function automatic logic [PW-1:0] pat(input int r, input int c, input int base);
    return PW'(base | (r << 4) | c);
  endfunction

  // mode 0: pattern; 1: random pixels. gap_pct: chance of idle cycles before each pixel.
  task automatic send_frame(input int base, input bit sof_first, input int gap_pct, input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) gap($urandom_range(1, 3));
        send(rnd ? PW'($urandom) : pat(r, c, base), sof_first && r == 0 && c == 0);
      end
  endtask

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor: pop the expected window whenever the DUT presents one.
  task automatic monitor();
    win_t e;
    logic [8:0][PW-1:0] got;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (frame_done && !out_valid)
        check(1'b0, "frame_done_alone", "frame_done=1 with out_valid=0, required out_valid=1");
      if (out_valid) begin
        win_seen++;
        if (frame_done) fd_seen++;
        got = {out_rd, out_rm, out_ru, out_md, out_mm, out_mu, out_ld, out_lm, out_lu};
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_window", $sformatf("got window x=%0d y=%0d, required none", out_x, out_y));
        end else begin
          e = exp_q.pop_front();
          check(got == e.taps && int'(out_x) == e.x && int'(out_y) == e.y && frame_done == e.fd,
                "window",
                $sformatf("got x=%0d y=%0d fd=%0b taps=%h, required x=%0d y=%0d fd=%0b taps=%h",
                          out_x, out_y, frame_done, got, e.x, e.y, e.fd, e.taps));
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check(exp_q.size() == 0, name, $sformatf("%0d windows outstanding, required 0", exp_q.size()));
    exp_q.delete();
  endtask

  task automatic check_counts(input string name, input int wins, input int fds);
    check(win_seen == wins && fd_seen == fds, name,
          $sformatf("got windows=%0d frame_done=%0d, required windows=%0d frame_done=%0d",
                    win_seen, fd_seen, wins, fds));
    win_seen = 0;
    fd_seen  = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check(out_valid == 1'b0 && frame_done == 1'b0 && out_x == '0 && out_y == '0 &&
          {out_lu, out_lm, out_ld, out_mu, out_mm, out_md, out_ru, out_rm, out_rd} == '0,
          name,
          $sformatf("got valid=%0b fd=%0b x=%0d y=%0d mm=%h rd=%h, required all 0",
                    out_valid, frame_done, out_x, out_y, out_mm, out_rd));
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    for (int i = 0; i < n; i++) step();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    mc  = 0;
    mr  = 0;
    #1;
  endtask

  initial begin
    checks = 0; fails = 0; win_seen = 0; fd_seen = 0;
    mc = 0; mr = 0; mon_en = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    fork monitor(); join_none
    step();
    do_reset(3);
    mon_en = 1'b1;

    // 1: continuous full frame with in_sof
    send_frame(0, 1'b1, 0, 1'b0);
    drain("t1_drain");
    check_counts("t1_counts", (W-2)*(H-2), 1);

    // 2: same frame with random gaps
    send_frame(0, 1'b1, 50, 1'b0);
    drain("t2_drain");
    check_counts("t2_counts", (W-2)*(H-2), 1);

    // 3: in_sof at (4,3) starts a fresh frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (!(r == 3 && c >= 4)) send(pat(r, c, 0), r == 0 && c == 0);
    drain("t3_partial_drain");
    win_seen = 0; fd_seen = 0;
    send_frame(12'h400, 1'b1, 0, 1'b0);
    drain("t3_drain");
    check_counts("t3_counts", (W-2)*(H-2), 1);

    // 4: one-cycle reset at (5,3), then full frame without in_sof
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (!(r == 3 && c > 5)) send(pat(r, c, 12'h200), r == 0 && c == 0);
    drain("t4_partial_drain");
    win_seen = 0; fd_seen = 0;
    do_reset(1);
    send_frame(0, 1'b0, 0, 1'b0);
    drain("t4_drain");
    check_counts("t4_counts", (W-2)*(H-2), 1);

    // 5: two back-to-back frames, second without in_sof and with bit 11 set
    send_frame(0, 1'b1, 0, 1'b0);
    send_frame(12'h800, 1'b0, 0, 1'b0);
    drain("t5_drain");
    check_counts("t5_counts", 2*(W-2)*(H-2), 2);

    // 6: random pixels with gaps over two frames
    send_frame(0, 1'b1, 30, 1'b1);
    send_frame(0, 1'b0, 30, 1'b1);
    drain("t6_drain");
    check_counts("t6_counts", 2*(W-2)*(H-2), 2);

    gap(4);
    check_counts("idle_no_windows", 0, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
